// File: rtl/evg_pkg.sv
// evg_pkg: event-generator shared event-code width, null code and reserved codes
package evg_pkg;
    localparam int EVCODE_WIDTH = 8;
    typedef logic [EVCODE_WIDTH-1:0] evcode_t;
    localparam evcode_t EVCODE_NULL       = 8'h00;
    localparam evcode_t EVCODE_HEARTBEAT  = 8'h7A;
    localparam evcode_t EVCODE_SEC_SHIFT0 = 8'h70;
    localparam evcode_t EVCODE_SEC_SHIFT1 = 8'h71;
    localparam evcode_t EVCODE_SEC_LATCH  = 8'h7D;
endpackage

// File: rtl/evg_rr_pick.sv
// evg_rr_pick: first set request bit at or after ptr, wrapping modulo N
//   req   : request vector
//   ptr   : search start index (< N)
//   idx   : index of the selected request
//   found : at least one request bit is set
module evg_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx = '0;
        found = 1'b0;
        // Walk the offsets downwards so the smallest offset from ptr wins.
        for (int i = N - 1; i >= 0; i--) begin
            logic [IW:0] s;
            logic [IW-1:0] j;
            s = {1'b0, ptr} + (IW+1)'(i);
            j = (s >= (IW+1)'(N)) ? IW'(s - (IW+1)'(N)) : IW'(s);
            if (req[j]) begin
                idx = j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/evg_event_arbiter.sv
// evg_event_arbiter: grants one requester per evgTxClk into the registered event-code slot
//   evgTxClk, evgTxReset_n : clock, async active-low reset
//   evgEnable, evgHold     : arbitration enable, formatter owns the slot
//   evgReqValid/Code/Ready : per-requester valid, 8-bit code, one-hot grant
//   evgEventValid/Code     : registered event output (code 0x00 when idle)
//   evgGrantIndex          : registered index of the last granted requester
//   evgDiscardCount        : saturating count of accepted null codes
module evg_event_arbiter
    import evg_pkg::*;
#(
    parameter int REQUESTER_COUNT = 4,
    parameter logic [REQUESTER_COUNT-1:0] PRIORITY_MASK = {{(REQUESTER_COUNT-1){1'b0}}, 1'b1},
    parameter int DISCARD_COUNT_WIDTH = 16,
    parameter string DEBUG = "false",
    localparam int N = REQUESTER_COUNT,
    localparam int IW = $clog2(REQUESTER_COUNT),
    localparam int DW = DISCARD_COUNT_WIDTH
) (
    input  logic                    evgTxClk,
    input  logic                    evgTxReset_n,
    input  logic                    evgEnable,
    input  logic                    evgHold,
    input  logic [N-1:0]            evgReqValid,
    input  logic [EVCODE_WIDTH*N-1:0] evgReqCode,
    output logic [N-1:0]            evgReqReady,
    output logic                    evgEventValid,
    output logic [EVCODE_WIDTH-1:0] evgEventCode,
    output logic [IW-1:0]           evgGrantIndex,
    output logic [DW-1:0]           evgDiscardCount
);
    logic [IW-1:0] ptr_q, grant_idx_q, u_idx, r_idx, g;
    logic u_found, r_found, grant, valid_q;
    evcode_t code, code_q;
    logic [DW-1:0] disc_q;
    logic [N-1:0] ready;

    evg_rr_pick #(.N(N)) u_urgent (
        .req(evgReqValid & PRIORITY_MASK), .ptr('0), .idx(u_idx), .found(u_found)
    );

    evg_rr_pick #(.N(N)) u_rr (
        .req(evgReqValid & ~PRIORITY_MASK), .ptr(ptr_q), .idx(r_idx), .found(r_found)
    );

    // Reset is folded in so ready stays low while reset is asserted.
    always_comb begin
        grant = evgTxReset_n && evgEnable && !evgHold && (u_found || r_found);
        g = u_found ? u_idx : r_idx;
        code = evgReqCode[g*EVCODE_WIDTH +: EVCODE_WIDTH];
        ready = grant ? (N'(1) << g) : '0;
    end

    always_ff @(posedge evgTxClk or negedge evgTxReset_n) begin
        if (!evgTxReset_n) begin
            valid_q <= 1'b0;
            code_q <= EVCODE_NULL;
            grant_idx_q <= '0;
            ptr_q <= '0;
            disc_q <= '0;
        end else begin
            valid_q <= grant && code != EVCODE_NULL;
            code_q <= grant ? code : EVCODE_NULL;
            if (grant) grant_idx_q <= g;
            // Urgent grants leave the round-robin rotation untouched.
            if (grant && !u_found) ptr_q <= (g == IW'(N - 1)) ? '0 : g + 1'b1;
            if (grant && code == EVCODE_NULL && disc_q != '1) disc_q <= disc_q + 1'b1;
        end
    end

    localparam int OW = N + 1 + EVCODE_WIDTH + IW + DW;
    logic [OW-1:0] out_bus;
    assign out_bus = {ready, valid_q, code_q, grant_idx_q, disc_q};

    if (DEBUG == "true") begin : g_dbg
        (* mark_debug = "true" *) logic [OW-1:0] dbg;
        assign dbg = out_bus;
        assign {evgReqReady, evgEventValid, evgEventCode, evgGrantIndex, evgDiscardCount} = dbg;
    end else begin : g_nodbg
        assign {evgReqReady, evgEventValid, evgEventCode, evgGrantIndex, evgDiscardCount} = out_bus;
    end
endmodule

// File: tb/tb_evg_event_arbiter.sv
// tb_evg_event_arbiter: directed and randomized checks of evg_event_arbiter against a behavioural model
module tb_evg_event_arbiter;
    localparam int N = 4;
    localparam logic [3:0] MASK = 4'b0001;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, hold = 1'b0;
    logic [3:0] valid = '0;
    logic [31:0] code = '0;
    logic [3:0] ready;
    logic ev_valid;
    logic [7:0] ev_code;
    logic [1:0] gidx;
    logic [15:0] disc;

    always #5 clk = ~clk;

    evg_event_arbiter #(
        .REQUESTER_COUNT(N), .PRIORITY_MASK(MASK), .DISCARD_COUNT_WIDTH(16), .DEBUG("false")
    ) dut (
        .evgTxClk(clk), .evgTxReset_n(rst_n), .evgEnable(en), .evgHold(hold),
        .evgReqValid(valid), .evgReqCode(code), .evgReqReady(ready),
        .evgEventValid(ev_valid), .evgEventCode(ev_code), .evgGrantIndex(gidx),
        .evgDiscardCount(disc)
    );

    int n_cmp = 0, n_err = 0;
    int m_ptr = 0, m_idx = 0, m_disc = 0, m_code = 0;
    bit m_valid = 0;
    logic [3:0] xfer = '0;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_idx = 0; m_disc = 0; m_code = 0; m_valid = 0;
    endfunction

    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin : cmp
        int g, c;
        bit urg;
        logic [3:0] er;
        chk("ev_valid", ev_valid, m_valid);
        chk("ev_code", ev_code, m_code);
        chk("grant_idx", gidx, m_idx);
        chk("discard", disc, m_disc);
        g = -1;
        for (int i = N - 1; i >= 0; i--) if (valid[i] && MASK[i]) g = i;
        urg = g >= 0;
        if (!urg)
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && valid[j] && !MASK[j]) g = j;
            end
        if (!rst_n || !en || hold) g = -1;
        er = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("ready", ready, er);
        xfer = er & valid;
        if (rst_n) begin
            c = (g >= 0) ? int'(code[g*8 +: 8]) : 0;
            m_valid = g >= 0 && c != 0;
            m_code = c;
            if (g >= 0) m_idx = g;
            if (g >= 0 && !urg) m_ptr = (g + 1) % N;
            if (g >= 0 && c == 0 && m_disc < 65535) m_disc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        valid = '0;
        hold = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic rand_phase(int cycles);
        for (int t = 0; t < cycles; t++) begin
            tick();
            en = ($urandom % 10) != 0;
            hold = ($urandom % 6) == 0;
            for (int i = 0; i < N; i++)
                if (xfer[i] || !valid[i]) begin
                    valid[i] = ($urandom % 2) == 1;
                    code[i*8 +: 8] = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
                end
        end
    endtask

    initial begin
        en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t1_ready", ready, 0);
            chk("t1_valid", ev_valid, 0);
            chk("t1_code", ev_code, 0);
        end
        chk("t1_disc", disc, 0);

        tick();
        code = {8'h33, 8'h22, 8'h11, 8'h00};
        valid = 4'b1110;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t2_code", ev_code, 'h11 * ((k % 3) + 1));
            chk("t2_valid", ev_valid, 1);
        end

        do_reset();
        valid = 4'b0010; code[15:8] = 8'h44;
        @(negedge clk); chk("t3_ready_r1", ready, 4'b0010);
        tick();
        valid = 4'b0101; code[7:0] = 8'h7A; code[23:16] = 8'h22;
        @(negedge clk); chk("t3_ready_urg", ready, 4'b0001); chk("t3_code44", ev_code, 8'h44);
        tick();
        valid = 4'b0100;
        @(negedge clk); chk("t3_ready_r2", ready, 4'b0100); chk("t3_code7a", ev_code, 8'h7A); chk("t3_idx0", gidx, 0);
        tick();
        valid = 4'b1010; code[31:24] = 8'h33; code[15:8] = 8'h55;
        @(negedge clk); chk("t3_code22", ev_code, 8'h22); chk("t3_idx2", gidx, 2); chk("t3_ptr3", ready, 4'b1000);
        tick();
        valid = '0;
        @(negedge clk); chk("t3_code33", ev_code, 8'h33);

        do_reset();
        hold = 1'b1; valid = 4'b0010; code[15:8] = 8'h44;
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_ready", ready, 0);
            chk("t4_hold_valid", ev_valid, 0);
        end
        tick();
        hold = 1'b0;
        @(negedge clk); chk("t4_ready", ready, 4'b0010);
        tick();
        valid = '0;
        @(negedge clk); chk("t4_code", ev_code, 8'h44); chk("t4_valid", ev_valid, 1);

        do_reset();
        valid = 4'b1000; code[31:24] = 8'h00;
        repeat (5) tick();
        valid = '0;
        @(negedge clk); chk("t5_disc5", disc, 5); chk("t5_valid", ev_valid, 0); chk("t5_idx", gidx, 3);
        tick();
        valid = 4'b1000;
        repeat (65539) tick();
        valid = '0;
        @(negedge clk); chk("t5_sat", disc, 16'hFFFF);

        do_reset();
        valid = 4'b0010; code[15:8] = 8'h11;
        tick();
        valid = 4'b0100; code[23:16] = 8'h22;
        @(negedge clk); chk("t6_code11", ev_code, 8'h11); chk("t6_ready", ready, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", ev_valid, 0); chk("t6_async_code", ev_code, 0);
        chk("t6_async_ready", ready, 0); chk("t6_async_idx", gidx, 0);
        @(posedge clk);
        #2;
        valid = 4'b1010; code[15:8] = 8'h11; code[31:24] = 8'h33;
        rst_n = 1'b1;
        @(negedge clk); chk("t6_ptr0", ready, 4'b0010); chk("t6_lost", ev_valid, 0);
        tick();
        valid = '0;
        @(negedge clk); chk("t6_code", ev_code, 8'h11); chk("t6_idx", gidx, 1);

        rand_phase(3000);
        tick();
        valid = '0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/evg_event_arbiter.md
Name: evg_event_arbiter

Overview:
- Shares the single event-code slot of the event generator's transmit stream among several requesters: sequencer, hardware triggers, software triggers and heartbeat.
- Each requester presents an 8-bit event code with a valid/ready handshake. The block grants at most one request per evgTxClk cycle and drives a registered event code to the transceiver-side encoder.
- Arbitration is fixed priority for a configurable urgent subset of requesters and round-robin for the rest.
- Sits in the evgTxClk domain between the event sources and the 16-bit TX word formatter.

Parameters:
- REQUESTER_COUNT, 4, number of requesters N (2..16).
- PRIORITY_MASK, 4'b0001, N-bit mask. A set bit marks a requester as urgent (fixed priority, lowest index wins).
- DISCARD_COUNT_WIDTH, 16, width of the saturating discard counter.
- DEBUG, "false", mark_debug attribute on output ports.

Ports:
- evgTxClk, input, 1, transmit clock; the only clock.
- evgTxReset_n, input, 1, asynchronous active-low reset.
- evgEnable, input, 1, arbitration enable. Level-sensitive, synchronous to evgTxClk.
- evgHold, input, 1, formatter is using the slot (seconds/shift insertion); no grant this cycle.
- evgReqValid, input, N, per-requester request valid.
- evgReqCode, input, 8*N, per-requester event code. Requester i uses bits [8i+7:8i].
- evgReqReady, output, N, one-hot grant. Combinational from evgReqValid, evgEnable, evgHold and arbiter state.
- evgEventValid, output, 1, registered: evgEventCode carries a granted event.
- evgEventCode, output, 8, registered event code; 0x00 when idle.
- evgGrantIndex, output, $clog2(N), registered index of the last granted requester.
- evgDiscardCount, output, DISCARD_COUNT_WIDTH, saturating count of requests discarded because their code was 0x00.

Behaviour:
- Reset (asynchronous assert, synchronous release): evgEventValid=0, evgEventCode=0x00, evgGrantIndex=0, round-robin pointer=0, evgDiscardCount=0. evgReqReady=0 while reset is asserted.
- Reset mid-transfer: a granted-but-unregistered request is lost. Requesters must re-present after reset.
- Transfer rule: requester i transfers when evgReqValid[i] && evgReqReady[i]. At most one bit of evgReqReady is set per cycle.
- Requesters must hold valid and code stable until ready. The arbiter never depends on a requester lowering valid without a grant.
- Grant eligibility: no grant when evgEnable=0 or evgHold=1. In those cycles evgReqReady=0, and on the next edge evgEventValid<=0 and evgEventCode<=0x00.
- Urgent stage: if (evgReqValid & PRIORITY_MASK) != 0, grant the lowest set index among them. The round-robin pointer is unchanged.
- Round-robin stage, used otherwise: candidates are evgReqValid & ~PRIORITY_MASK. Grant the first candidate at index >= pointer, wrapping modulo N.
- After a round-robin grant of index g, the pointer becomes (g+1) mod N. When g = N-1 the pointer wraps to 0.
- No candidates: no grant; idle output next cycle.
- Latency: exactly one evgTxClk edge from transfer to output. On that edge evgEventValid<=1, evgEventCode<=granted code, evgGrantIndex<=g.
- Back-to-back grants are allowed every cycle. Full throughput is 1 event/cycle.
- Null code: a transfer with code 0x00 is accepted (ready asserted, requester released). On the next edge evgEventValid<=0, evgEventCode<=0x00 and evgGrantIndex<=g. evgDiscardCount increments, saturating at all-ones.
- Simultaneous events:
  - evgHold overrides everything.
  - Urgent beats round-robin.
  - Among urgent requesters, the lower index wins.
- Enable deassert mid-stream: the event already registered is still output. No further grants are made. The pointer is retained.

Decomposition:
- Shared package evg_pkg holds:
  - EVCODE_WIDTH=8.
  - EVCODE_NULL=8'h00.
  - the reserved code constants used elsewhere in the event generator (heartbeat 8'h7A, seconds shift 8'h70/8'h71, seconds latch 8'h7D).
- Sub-module evg_rr_pick: combinational "first set bit at or after pointer, with wrap". Parameterized by N; returns index and a found flag.
  - It is instantiated once for the round-robin stage.
  - It is instantiated again with pointer tied to 0 for the urgent stage.

Test Plan:
- Reset release, N=4, all valid=0 → ready=0; evgEventValid=0, evgEventCode=0x00 on every cycle; evgDiscardCount=0.
- Requesters 1,2,3 valid continuously with codes 0x11, 0x22, 0x33; mask=0001; req0 idle → output cycles 0x11, 0x22, 0x33, 0x11..., one per cycle, starting one cycle after the first grant.
- Req0 (urgent, code 0x7A) and req2 (0x22) valid together; pointer=2 → req0 granted first, 0x7A output; pointer stays 2; req2 granted next cycle, 0x22 output; pointer becomes 3.
- evgHold high for 3 cycles while req1 valid (0x44) → ready=0 for those 3 cycles; idle output; req1 granted the cycle hold falls; 0x44 output one cycle later.
- Req3 presents 0x00 five times → each accepted; no evgEventValid; evgDiscardCount=5. Force 2^16+3 discards → count holds at 0xFFFF.
- evgTxReset_n pulsed low mid-stream with req2 granted → outputs clear immediately, asynchronously; pointer=0 after release; req2's event never appears.
